uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx serializer between several byte-stream requesters (logger, command-response unit, debug dumper).
- Grants are round-robin at frame granularity. A granted requester keeps the UART until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and uart_tx on clock0. Drives uart_tx start_tx/data and observes uart_tx ready.

---
 rtl/uart_tx_arbiter_if.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: groups the requester-side and uart_tx-side signals of
// the UART transmit arbiter.
//
// Signals:
//   i_reqValid  [N]    per-requester byte valid (bit n = requester n)
//   i_reqData   [N*W]  packed bytes, requester n at [n*W +: W]
//   i_reqLast   [N]    byte closes its frame
//   o_reqReady  [N]    one-cycle accept pulse to requester n
//   i_txReady          uart_tx ready
//   o_txValid          one-cycle start pulse to uart_tx
//   o_txData    [W]    byte to uart_tx, held until the next accept
//   o_grant     [N]    one-hot current owner, 0 when nobody owns the UART
//   o_busy             arbiter is not idle
//   o_timeout          one-cycle pulse when a grant is revoked by timeout
//   dbg_state   [2]    arbiter FSM state (0 idle, 1 issue, 2 wait_busy, 3 wait_done)
//
// Handshake: a requester raises i_reqValid[n] with i_reqData/i_reqLast and
// holds all three stable until it sees o_reqReady[n]; it may present the next
// byte from the following cycle. o_txValid is a start pulse; uart_tx drops
// i_txReady at least one cycle after sampling it and raises it when done.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQUESTERS = 2,
    parameter int UART_DATA_SIZE = 8
);
    logic [NUM_REQUESTERS-1:0]                i_reqValid;
    logic [NUM_REQUESTERS*UART_DATA_SIZE-1:0] i_reqData;
    logic [NUM_REQUESTERS-1:0]                i_reqLast;
    logic [NUM_REQUESTERS-1:0]                o_reqReady;
    logic                                     i_txReady;
    logic                                     o_txValid;
    logic [UART_DATA_SIZE-1:0]                o_txData;
    logic [NUM_REQUESTERS-1:0]                o_grant;
    logic                                     o_busy;
    logic                                     o_timeout;
    logic [1:0]                               dbg_state;

    // Arbiter side.
    modport slave (
        input  i_reqValid, i_reqData, i_reqLast, i_txReady,
        output o_reqReady, o_txValid, o_txData, o_grant, o_busy, o_timeout,
               dbg_state
    );

    // Requester / uart_tx side.
    modport master (
        output i_reqValid, i_reqData, i_reqLast, i_txReady,
        input  o_reqReady, o_txValid, o_txData, o_grant, o_busy, o_timeout,
               dbg_state
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between several byte-stream
// requesters. Ownership is granted round-robin per frame; the owner keeps the
// UART until it sends a byte flagged last, or until it leaves valid low for
// FRAME_TIMEOUT consecutive cycles while the arbiter waits for its next byte.
//
// Ports:
//   i_clock   system clock
//   i_nReset  synchronous, active-low reset
//   bus       uart_tx_arbiter_if.slave (requester and uart_tx signals)
//
// All outputs are registered.
module uart_tx_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int UART_DATA_SIZE = 8,
    parameter int FRAME_TIMEOUT  = 1_000_000
) (
    input  logic                   i_clock,
    input  logic                   i_nReset,
    uart_tx_arbiter_if.slave       bus
);
    localparam int GW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [GW-1:0]               owner_q, owner_d;
    logic [GW-1:0]               last_grant_q, last_grant_d;
    logic                        last_flag_q, last_flag_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        tx_valid_q, tx_valid_d;
    logic [UART_DATA_SIZE-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQUESTERS-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQUESTERS-1:0]   grant_q, grant_d;
    logic                        busy_q, busy_d;
    logic                        timeout_q, timeout_d;
    logic [GW-1:0]               pick;

    // First requester with valid set, scanning last+1, last+2, ... modulo N.
    // The loop runs from the farthest candidate down so the nearest one wins.
    function automatic logic [GW-1:0] rr_pick(
        input logic [NUM_REQUESTERS-1:0] valid,
        input logic [GW-1:0]             last
    );
        logic [GW-1:0] sel;
        int            idx;
        sel = last;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQUESTERS) begin
                idx = idx - NUM_REQUESTERS;
            end
            if (valid[idx]) begin
                sel = GW'(idx);
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        last_flag_d  = last_flag_q;
        cnt_d        = cnt_q;
        tx_valid_d   = 1'b0;
        tx_data_d    = tx_data_q;
        req_ready_d  = '0;
        grant_d      = grant_q;
        timeout_d    = 1'b0;
        pick         = rr_pick(bus.i_reqValid, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (|bus.i_reqValid) begin
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.i_txReady && bus.i_reqValid[owner_q]) begin
                    tx_valid_d           = 1'b1;
                    tx_data_d            = bus.i_reqData[owner_q*UART_DATA_SIZE +: UART_DATA_SIZE];
                    req_ready_d[owner_q] = 1'b1;
                    last_flag_d          = bus.i_reqLast[owner_q];
                    cnt_d                = '0;
                    state_d              = ST_WAIT_BUSY;
                end else if (!bus.i_reqValid[owner_q]) begin
                    // cnt_q holds the number of earlier consecutive low
                    // cycles, so this is the FRAME_TIMEOUT-th one.
                    if (cnt_q >= CNT_LAST) begin
                        timeout_d    = 1'b1;
                        grant_d      = '0;
                        last_grant_d = owner_q;
                        cnt_d        = CNT_MAX;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Owner is presenting a byte but uart_tx is not ready:
                    // the owner is not stalling, so the run restarts.
                    cnt_d = '0;
                end
            end
            ST_WAIT_BUSY: begin
                if (!bus.i_txReady) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.i_txReady) begin
                    if (last_flag_q) begin
                        last_grant_d = owner_q;
                        grant_d      = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock) begin
        if (!i_nReset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_grant_q <= GW'(NUM_REQUESTERS - 1);
            last_flag_q  <= 1'b0;
            cnt_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            req_ready_q  <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            last_flag_q  <= last_flag_d;
            cnt_q        <= cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            req_ready_q  <= req_ready_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_txValid  = tx_valid_q;
    assign bus.o_txData   = tx_data_q;
    assign bus.o_reqReady = req_ready_q;
    assign bus.o_grant    = grant_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic for
// uart_tx_arbiter with four requesters and a short frame timeout. A
// transaction-level model (owner, round-robin pointer, per-requester byte
// queues) predicts every output on every cycle.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;
    localparam int FT = 16;

    logic clk = 1'b0;
    logic n_reset;
    initial forever #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQUESTERS(NR), .UART_DATA_SIZE(W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQUESTERS(NR),
        .UART_DATA_SIZE(W),
        .FRAME_TIMEOUT (FT)
    ) dut (
        .i_clock (clk),
        .i_nReset(n_reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester sources and expected bytes: {last, data}.
    logic [8:0] src_q[NR][$];
    logic [8:0] exp_q[NR][$];
    logic [NR-1:0] cur_valid;
    int  gap_cnt[NR];
    bit  rand_gaps = 0;

    // uart_tx model.
    int  uart_len  = 1;
    bit  rand_uart = 0;
    int  u_phase   = 0;
    int  u_cnt     = 0;

    // Reset requests from the main sequence.
    int  rst_req   = 0;
    bit  rst_flush = 0;

    // Reference model state.
    int         m_owner = -1;
    int         m_ptr   = NR - 1;
    int         m_phase = 0;
    int         m_low_run = 0;
    bit         m_saw_low = 0;
    bit         m_last = 0;
    logic [W-1:0] m_data = '0;
    logic [NR-1:0] pv;
    bit         pr, pn;

    // Pulses observed on the DUT outputs.
    int         log_own[$];
    logic [W-1:0] log_dat[$];
    int         log_cyc[$];
    int         last_tx_cyc = -100;
    int         timeouts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic int pick_gap();
        if (!rand_gaps) return 0;
        if ($urandom_range(0, 7) == 0) return int'($urandom_range(12, 24));
        return int'($urandom_range(0, 2));
    endfunction

    // One cycle: check outputs of the edge just passed, then drive inputs.
    task automatic step();
        logic [8:0]    e;
        logic [8:0]    h;
        bit            exp_pulse;
        bit            exp_to;
        logic [NR-1:0] exp_grant;
        logic [NR-1:0] exp_rr;
        cyc++;
        exp_pulse = 0;
        exp_to    = 0;
        exp_rr    = '0;

        if (!pn) begin
            chk("reset_grant",    bus.o_grant,    0);
            chk("reset_tx_valid", bus.o_txValid,  0);
            chk("reset_req_ready", bus.o_reqReady, 0);
            chk("reset_busy",     bus.o_busy,     0);
            chk("reset_timeout",  bus.o_timeout,  0);
            chk("reset_tx_data",  bus.o_txData,   0);
            m_owner = -1;
            m_ptr   = NR - 1;
            m_data  = '0;
            last_tx_cyc = -100;
        end else begin
            if (m_owner < 0) begin
                if (pv != '0) begin
                    m_owner   = rr_pick(pv, m_ptr);
                    m_phase   = 0;
                    m_low_run = 0;
                end
            end else if (m_phase == 0) begin
                if (pv[m_owner] && pr) begin
                    exp_pulse = 1;
                    exp_rr    = NR'(1) << m_owner;
                    if (exp_q[m_owner].size() == 0) begin
                        errors++;
                        $display("FAIL model_queue at cycle %0d: requester %0d accepted with no byte expected", cyc, m_owner);
                    end else begin
                        e      = exp_q[m_owner].pop_front();
                        m_data = e[W-1:0];
                        m_last = e[8];
                    end
                    m_phase   = 1;
                    m_saw_low = 0;
                end else if (!pv[m_owner]) begin
                    m_low_run++;
                    if (m_low_run == FT) begin
                        exp_to  = 1;
                        m_ptr   = m_owner;
                        m_owner = -1;
                    end
                end else begin
                    m_low_run = 0;
                end
            end else begin
                if (!m_saw_low) begin
                    if (!pr) m_saw_low = 1;
                end else if (pr) begin
                    if (m_last) begin
                        m_ptr   = m_owner;
                        m_owner = -1;
                    end else begin
                        m_phase   = 0;
                        m_low_run = 0;
                    end
                end
            end
            exp_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
            chk("grant",     bus.o_grant,    exp_grant);
            chk("busy",      bus.o_busy,     exp_grant != '0);
            chk("timeout",   bus.o_timeout,  exp_to);
            chk("tx_valid",  bus.o_txValid,  exp_pulse);
            chk("req_ready", bus.o_reqReady, exp_rr);
            chk("tx_data",   bus.o_txData,   m_data);
        end

        if (bus.o_timeout) timeouts++;
        if (bus.o_txValid) begin
            chk("pulse_spacing_ge4", (cyc - last_tx_cyc) >= 4, 1);
            chk("uart_idle_at_start", u_phase == 0, 1);
            log_own.push_back(onehot_idx(bus.o_reqReady));
            log_dat.push_back(bus.o_txData);
            log_cyc.push_back(cyc);
            last_tx_cyc = cyc;
        end

        // Requesters: retire accepted bytes, then present the next one.
        for (int n = 0; n < NR; n++) begin
            if (cur_valid[n] && bus.o_reqReady[n]) begin
                void'(src_q[n].pop_front());
                cur_valid[n] = 1'b0;
                gap_cnt[n]   = pick_gap();
            end
        end
        if (rst_req > 0) begin
            n_reset = 1'b0;
            rst_req--;
            if (rst_flush) begin
                for (int n = 0; n < NR; n++) begin
                    src_q[n].delete();
                    exp_q[n].delete();
                    cur_valid[n] = 1'b0;
                    gap_cnt[n]   = 0;
                end
                rst_flush = 0;
            end
        end else begin
            n_reset = 1'b1;
        end
        for (int n = 0; n < NR; n++) begin
            if (!cur_valid[n] && src_q[n].size() > 0) begin
                if (gap_cnt[n] > 0) gap_cnt[n]--;
                else cur_valid[n] = 1'b1;
            end
            if (cur_valid[n]) begin
                h = src_q[n][0];
                bus.i_reqData[n*W +: W] = h[W-1:0];
                bus.i_reqLast[n]        = h[8];
            end else begin
                bus.i_reqData[n*W +: W] = '0;
                bus.i_reqLast[n]        = 1'b0;
            end
        end
        bus.i_reqValid = cur_valid;

        // uart_tx: drop ready the cycle after sampling start, stay busy u_cnt cycles.
        case (u_phase)
            0: if (bus.o_txValid) u_phase = 1;
            1: begin
                bus.i_txReady = 1'b0;
                u_cnt   = rand_uart ? int'($urandom_range(1, 6)) : uart_len;
                u_phase = 2;
            end
            default: begin
                u_cnt--;
                if (u_cnt == 0) begin
                    bus.i_txReady = 1'b1;
                    u_phase = 0;
                end
            end
        endcase

        pv = bus.i_reqValid;
        pr = bus.i_txReady;
        pn = n_reset;
    endtask

    initial begin
        n_reset        = 1'b0;
        bus.i_reqValid = '0;
        bus.i_reqData  = '0;
        bus.i_reqLast  = '0;
        bus.i_txReady  = 1'b1;
        cur_valid      = '0;
        for (int n = 0; n < NR; n++) gap_cnt[n] = 0;
        pv = '0;
        pr = 1'b1;
        pn = 1'b0;
        forever begin
            @(negedge clk);
            step();
        end
    end

    task automatic push_byte(input int n, input logic [W-1:0] d, input bit last);
        src_q[n].push_back({last, d});
        exp_q[n].push_back({last, d});
    endtask

    task automatic clear_log();
        log_own.delete();
        log_dat.delete();
        log_cyc.delete();
        timeouts = 0;
    endtask

    task automatic do_reset();
        int budget = 20;
        rst_flush = 1;
        rst_req   = 2;
        while ((rst_req > 0 || n_reset == 1'b0) && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (budget == 0) begin
            errors++;
            $display("FAIL reset_sequence at cycle %0d: reset did not complete", cyc);
        end
        clear_log();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int total;
        bit done = 0;
        while (!done && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
            done = (bus.o_grant == '0) && !bus.o_busy && (u_phase == 0) && (cur_valid == '0);
            for (int n = 0; n < NR; n++) if (src_q[n].size() != 0) done = 0;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_idle_timeout at cycle %0d: arbiter never drained", name, cyc);
        end else begin
            total = 0;
            for (int n = 0; n < NR; n++) total += exp_q[n].size();
            chk({name, "_exp_drained"}, total, 0);
        end
    endtask

    task automatic chk_entry(input string name, input int i, input int own, input logic [W-1:0] dat);
        if (i < log_own.size()) begin
            chk({name, "_owner"}, log_own[i], own);
            chk({name, "_data"},  log_dat[i], dat);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_missing at cycle %0d: pulse %0d never seen, log has %0d", name, cyc, i, log_own.size());
        end
    endtask

    task automatic chk_gap(input string name, input int i, input int exp_gap);
        if (i + 1 < log_cyc.size()) begin
            chk(name, log_cyc[i+1] - log_cyc[i], exp_gap);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s_missing at cycle %0d: only %0d pulses", name, cyc, log_cyc.size());
        end
    endtask

    initial begin
        int gcount;
        int budget;
        @(posedge clk);
        #2;

        // 1: valid held high through reset; requester 0 wins, frame in order.
        rst_req = 3;
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
        push_byte(1, 8'h51, 1); push_byte(2, 8'h61, 1); push_byte(3, 8'h71, 1);
        wait_idle("t1", 500);
        chk_entry("t1_p0", 0, 0, 8'h41);
        chk_entry("t1_p1", 1, 0, 8'h42);
        chk_entry("t1_p2", 2, 0, 8'h43);
        chk_entry("t1_p3", 3, 1, 8'h51);
        chk_entry("t1_p4", 4, 2, 8'h61);
        chk_entry("t1_p5", 5, 3, 8'h71);
        chk_gap("t1_min_spacing", 0, 4);

        // 2: two simultaneous rounds of 2-byte frames, served 0,0,1,1 twice.
        do_reset();
        push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 1);
        push_byte(1, 8'hB0, 0); push_byte(1, 8'hB1, 1);
        wait_idle("t2a", 500);
        push_byte(0, 8'hC0, 0); push_byte(0, 8'hC1, 1);
        push_byte(1, 8'hD0, 0); push_byte(1, 8'hD1, 1);
        wait_idle("t2b", 500);
        chk_entry("t2_p0", 0, 0, 8'hA0);
        chk_entry("t2_p1", 1, 0, 8'hA1);
        chk_entry("t2_p2", 2, 1, 8'hB0);
        chk_entry("t2_p3", 3, 1, 8'hB1);
        chk_entry("t2_p4", 4, 0, 8'hC0);
        chk_entry("t2_p6", 6, 1, 8'hD0);

        // 3: requester 1 stalls after a non-last byte; grant revoked, 0 next.
        do_reset();
        uart_len = 1;
        push_byte(1, 8'h10, 0);
        budget = 100;
        while (bus.o_grant != 4'b0010 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        gcount = 0;
        if (bus.o_grant == 4'b0010) begin
            push_byte(0, 8'h20, 1);
            budget = 200;
            while (bus.o_grant == 4'b0010 && budget > 0) begin
                gcount++;
                @(posedge clk);
                #2;
                budget--;
            end
        end
        chk("t3_grant_cycles", gcount, 20);
        wait_idle("t3", 500);
        chk("t3_timeouts", timeouts, 1);
        chk_entry("t3_p0", 0, 1, 8'h10);
        chk_entry("t3_p1", 1, 0, 8'h20);

        // 4: slow uart_tx, ready low for 20 cycles after each start.
        do_reset();
        uart_len = 20;
        push_byte(2, 8'h31, 0); push_byte(2, 8'h32, 0); push_byte(2, 8'h33, 1);
        wait_idle("t4", 500);
        chk_gap("t4_slow_spacing_a", 0, 23);
        chk_gap("t4_slow_spacing_b", 1, 23);

        // 5: reset while waiting for uart_tx to go busy; frame restarts.
        do_reset();
        push_byte(0, 8'h55, 0); push_byte(0, 8'h56, 1);
        budget = 100;
        while (log_own.size() == 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        chk("t5_first_pulse_seen", log_own.size(), 1);
        do_reset();
        push_byte(0, 8'h57, 0); push_byte(0, 8'h58, 1);
        wait_idle("t5", 500);
        chk_entry("t5_p0", 0, 0, 8'h57);
        chk_entry("t5_p1", 1, 0, 8'h58);
        uart_len = 1;

        // 6: pointer at 1, requesters 1 and 3 pending -> 3 first.
        do_reset();
        push_byte(1, 8'h61, 1);
        wait_idle("t6a", 200);
        push_byte(1, 8'h62, 1);
        push_byte(3, 8'h63, 1);
        wait_idle("t6b", 200);
        chk_entry("t6_p0", 0, 1, 8'h61);
        chk_entry("t6_p1", 1, 3, 8'h63);
        chk_entry("t6_p2", 2, 1, 8'h62);

        // Randomized traffic: random frames, stalls, timeouts and uart latency.
        do_reset();
        rand_gaps = 1;
        rand_uart = 1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #2;
            for (int n = 0; n < NR; n++) begin
                if (src_q[n].size() < 4 && $urandom_range(0, 15) == 0) begin
                    int len;
                    bit close;
                    len   = int'($urandom_range(1, 4));
                    close = ($urandom_range(0, 9) != 0);
                    for (int b = 0; b < len; b++) begin
                        push_byte(n, W'($urandom_range(0, 255)), close && (b == len - 1));
                    end
                end
            end
        end
        wait_idle("rand", 6000);
        chk("rand_traffic_seen", log_own.size() > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
